// File: rtl/vos_pkg.sv
// Shared opcode/state types and decode helpers for the vector op scheduler.
package vos_pkg;

    typedef enum logic [7:0] {
        OP_NONE = 8'h00,
        OP_WR_A = 8'h01,
        OP_WR_B = 8'h02,
        OP_RD_A = 8'h03,
        OP_RD_B = 8'h04,
        OP_SUM  = 8'h05,
        OP_AVG  = 8'h06,
        OP_EUC  = 8'h07,
        OP_MAN  = 8'h08,
        OP_DOT  = 8'h09
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_LAUNCH,
        S_LOAD,
        S_SEND,
        S_WAIT_TX,
        S_SHIFT
    } state_e;

    localparam int EN_READ = 0;
    localparam int EN_SUM  = 1;
    localparam int EN_AVG  = 2;
    localparam int EN_EUC  = 3;
    localparam int EN_MAN  = 4;
    localparam int EN_DOT  = 5;
    localparam int EN_W    = 6;

    function automatic logic op_known(input logic [7:0] cmd);
        return (cmd >= 8'h01) && (cmd <= 8'h09);
    endfunction

    function automatic logic op_is_write(input opcode_e op);
        return (op == OP_WR_A) || (op == OP_WR_B);
    endfunction

    // Scalar reductions produce a single result word, everything else a full vector.
    function automatic int op_words(input opcode_e op, input int n);
        case (op)
            OP_WR_A, OP_WR_B, OP_RD_A, OP_RD_B, OP_SUM, OP_AVG: return n;
            OP_EUC, OP_MAN, OP_DOT:                             return 1;
            default:                                            return 0;
        endcase
    endfunction

    function automatic logic [EN_W-1:0] op_enables(input opcode_e op);
        logic [EN_W-1:0] en;
        en = '0;
        case (op)
            OP_RD_A, OP_RD_B: en[EN_READ] = 1'b1;
            OP_SUM:           en[EN_SUM]  = 1'b1;
            OP_AVG:           en[EN_AVG]  = 1'b1;
            OP_EUC:           en[EN_EUC]  = 1'b1;
            OP_MAN:           en[EN_MAN]  = 1'b1;
            OP_DOT:           en[EN_DOT]  = 1'b1;
            default:          en          = '0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/vos_edge_detect.sv
// Registered rising-edge detector for the command_ready level coming out of the CDC cell.
module vos_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (reset) level_q <= 1'b0;
        else       level_q <= level;
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/vector_op_scheduler.sv
// Sequences one host command across the vector datapath (single clk_process domain).
// Optional watchdog on the handshake waits is enabled by defining VOS_TIMEOUT_EN.
import vos_pkg::*;

module vector_op_scheduler #(
    parameter int NUM_ELEMENTOS = 8,
    parameter int PIPE_LATENCY  = 4
`ifdef VOS_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 2**24
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            command_ready,
    input  logic [7:0]      command,
    input  logic            write_done,
    input  logic            tx_sent,
    output logic            begin_write,
    output logic            begin_transmission,
    output logic            read_mem_sel,
    output logic            load_mem,
    output logic            shift_mem,
    output logic [EN_W-1:0] enables,
    output logic            busy,
    output logic            cmd_error
);

    localparam int CNT_W = $clog2(NUM_ELEMENTOS + 1);
    localparam int LAT_W = $clog2(PIPE_LATENCY + 1);

    state_e          state, next_state;
    opcode_e         cmd_op, op_q;
    logic            cmd_rise;
    logic            accept;
    logic [CNT_W-1:0] word_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic [EN_W-1:0] enables_q;
    logic            read_sel_q;
    logic            err_q;
    logic            timeout;

    vos_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .level (command_ready),
        .rise  (cmd_rise)
    );

    assign cmd_op = opcode_e'(command);
    assign accept = (state == S_IDLE) && cmd_rise && op_known(command);

`ifdef VOS_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            in_wait;

    assign in_wait = (state == S_WRITE) || (state == S_WAIT_TX);

    // A handshake arriving on the expiry cycle takes priority over the watchdog.
    assign timeout = ((state == S_WRITE && !write_done) || (state == S_WAIT_TX && !tx_sent))
                     && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset)                             wd_cnt <= '0;
        else if (in_wait && next_state == state) wd_cnt <= wd_cnt + WD_W'(1);
        else                                   wd_cnt <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        next_state         = state;
        begin_write        = 1'b0;
        begin_transmission = 1'b0;
        load_mem           = 1'b0;
        shift_mem          = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) next_state = op_is_write(cmd_op) ? S_WRITE : S_LAUNCH;
            end
            S_WRITE: begin
                begin_write = 1'b1;
                if (write_done) next_state = S_IDLE;
            end
            // LAUNCH spans PIPE_LATENCY+1 cycles so LOAD samples a settled core result.
            S_LAUNCH: begin
                if (lat_cnt == LAT_W'(PIPE_LATENCY)) next_state = S_LOAD;
            end
            S_LOAD: begin
                load_mem   = 1'b1;
                next_state = S_SEND;
            end
            S_SEND: begin
                begin_transmission = 1'b1;
                next_state         = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_sent) next_state = (word_cnt == CNT_W'(1)) ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                shift_mem  = 1'b1;
                next_state = S_SEND;
            end
            default: next_state = S_IDLE;
        endcase
        if (timeout) next_state = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= OP_NONE;
            word_cnt   <= '0;
            lat_cnt    <= '0;
            enables_q  <= '0;
            read_sel_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= next_state;
            err_q <= timeout || ((state == S_IDLE) && cmd_rise && !op_known(command));

            if (accept) op_q <= cmd_op;

            if (state == S_LAUNCH) lat_cnt <= lat_cnt + LAT_W'(1);
            else                   lat_cnt <= '0;

            if (state == S_LOAD)
                word_cnt <= CNT_W'(op_words(op_q, NUM_ELEMENTOS));
            else if (state == S_WAIT_TX && tx_sent)
                word_cnt <= word_cnt - CNT_W'(1);

            // Datapath selects stay frozen for the whole operation and drop with IDLE.
            if (next_state == S_IDLE) begin
                enables_q  <= '0;
                read_sel_q <= 1'b0;
            end else if (accept && !op_is_write(cmd_op)) begin
                enables_q  <= op_enables(cmd_op);
                read_sel_q <= (cmd_op == OP_RD_B);
            end
        end
    end

    assign enables      = enables_q;
    assign read_mem_sel = read_sel_q;
    assign cmd_error    = err_q;
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_vector_op_scheduler.sv
// Directed self-checking bench for vector_op_scheduler (NUM_ELEMENTOS=8, PIPE_LATENCY=4).
module tb_vector_op_scheduler;

    localparam int N  = 8;
    localparam int PL = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       command_ready;
    logic [7:0] command;
    logic       write_done;
    logic       tx_sent;
    logic       begin_write;
    logic       begin_transmission;
    logic       read_mem_sel;
    logic       load_mem;
    logic       shift_mem;
    logic [5:0] enables;
    logic       busy;
    logic       cmd_error;

    int checks = 0;
    int errors = 0;
    int n_tx = 0, n_shift = 0, n_load = 0;
    int tx0, sh0, ld0;

    vector_op_scheduler #(
        .NUM_ELEMENTOS (N),
        .PIPE_LATENCY  (PL)
`ifdef VOS_TIMEOUT_EN
        , .TIMEOUT_CYCLES (100)
`endif
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .command_ready      (command_ready),
        .command            (command),
        .write_done         (write_done),
        .tx_sent            (tx_sent),
        .begin_write        (begin_write),
        .begin_transmission (begin_transmission),
        .read_mem_sel       (read_mem_sel),
        .load_mem           (load_mem),
        .shift_mem          (shift_mem),
        .enables            (enables),
        .busy               (busy),
        .cmd_error          (cmd_error)
    );

    always #5 clk = ~clk;

    // Pulse tallies sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (begin_transmission) n_tx++;
        if (shift_mem)          n_shift++;
        if (load_mem)           n_load++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise command_ready for one cycle; returns one cycle after the edge.
    task automatic applyStimulus(input logic [7:0] cmd);
        command       = cmd;
        command_ready = 1'b1;
        tick();
        command_ready = 1'b0;
    endtask

    task automatic waitTx(input string tag);
        for (int i = 0; i < 200 && begin_transmission !== 1'b1; i++) tick();
        checkOutput(tag, {31'd0, begin_transmission}, 32'd1);
    endtask

    task automatic snap();
        tick();
        tx0 = n_tx; sh0 = n_shift; ld0 = n_load;
    endtask

    initial begin
        reset = 1'b1; command_ready = 1'b0; command = 8'h00;
        write_done = 1'b0; tx_sent = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        $display("[TB] reset state");
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_outs", {begin_write, begin_transmission, read_mem_sel, load_mem,
                                 shift_mem, cmd_error, enables}, 32'd0);

        $display("[TB] SUM with slow tx_sent and a dropped second edge");
        snap();
        applyStimulus(8'h05);
        checkOutput("sum_enables", {26'd0, enables}, 32'h02);
        checkOutput("sum_busy", {31'd0, busy}, 32'd1);
        checkOutput("sum_rdsel", {31'd0, read_mem_sel}, 32'd0);
        for (int w = 0; w < N; w++) begin
            waitTx("sum_tx_seen");
            checkOutput("sum_enables_held", {26'd0, enables}, 32'h02);
            if (w == 3) begin
                command = 8'h09; command_ready = 1'b1;
                tick();
                command_ready = 1'b0;
                repeat (19) tick();
            end else begin
                repeat (20) tick();
            end
            if (w == N - 1) checkOutput("sum_busy_before_last", {31'd0, busy}, 32'd1);
            tx_sent = 1'b1;
            tick();
            tx_sent = 1'b0;
        end
        checkOutput("sum_busy_done", {31'd0, busy}, 32'd0);
        checkOutput("sum_enables_clr", {26'd0, enables}, 32'd0);
        tick();
        checkOutput("sum_tx_count", n_tx - tx0, 32'd8);
        checkOutput("sum_shift_count", n_shift - sh0, 32'd7);
        checkOutput("sum_load_count", n_load - ld0, 32'd1);

        $display("[TB] WR_A with write_done at cycle 50");
        snap();
        applyStimulus(8'h01);
        checkOutput("wr_begin_write", {31'd0, begin_write}, 32'd1);
        checkOutput("wr_enables", {26'd0, enables}, 32'd0);
        tx_sent = 1'b1;
        tick();
        tx_sent = 1'b0;
        repeat (47) tick();
        checkOutput("wr_still_writing", {31'd0, begin_write}, 32'd1);
        write_done = 1'b1;
        tick();
        write_done = 1'b0;
        checkOutput("wr_begin_write_low", {31'd0, begin_write}, 32'd0);
        checkOutput("wr_busy_low", {31'd0, busy}, 32'd0);
        write_done = 1'b1;
        tick();
        write_done = 1'b0;
        checkOutput("wr_stray_done_idle", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("wr_no_tx", n_tx - tx0, 32'd0);
        checkOutput("wr_no_load", n_load - ld0, 32'd0);

        $display("[TB] DOT latency");
        snap();
        applyStimulus(8'h09);
        checkOutput("dot_enables", {26'd0, enables}, 32'h20);
        repeat (PL + 1) tick();
        checkOutput("dot_load", {31'd0, load_mem}, 32'd1);
        checkOutput("dot_tx_not_yet", {31'd0, begin_transmission}, 32'd0);
        tick();
        checkOutput("dot_tx_at_edge_plus_7", {31'd0, begin_transmission}, 32'd1);
        tick();
        tx_sent = 1'b1;
        tick();
        tx_sent = 1'b0;
        checkOutput("dot_busy_done", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("dot_tx_count", n_tx - tx0, 32'd1);
        checkOutput("dot_no_shift", n_shift - sh0, 32'd0);

        $display("[TB] unknown opcodes");
        applyStimulus(8'h3F);
        checkOutput("bad3f_err", {31'd0, cmd_error}, 32'd1);
        checkOutput("bad3f_busy", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("bad3f_err_pulse", {31'd0, cmd_error}, 32'd0);
        applyStimulus(8'h0A);
        checkOutput("bad0a_err", {31'd0, cmd_error}, 32'd1);
        tick();

        $display("[TB] reset during word 3 then RD_B");
        applyStimulus(8'h03);
        checkOutput("rda_enables", {26'd0, enables}, 32'h01);
        checkOutput("rda_rdsel", {31'd0, read_mem_sel}, 32'd0);
        for (int w = 0; w < 2; w++) begin
            waitTx("rda_tx_seen");
            tick(); tx_sent = 1'b1; tick(); tx_sent = 1'b0;
        end
        waitTx("rda_tx3_seen");
        tick();
        checkOutput("rda_in_wait", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_outs", {begin_write, begin_transmission, read_mem_sel, load_mem,
                                   shift_mem, cmd_error, enables}, 32'd0);
        snap();
        applyStimulus(8'h04);
        checkOutput("rdb_rdsel", {31'd0, read_mem_sel}, 32'd1);
        checkOutput("rdb_enables", {26'd0, enables}, 32'h01);
        for (int w = 0; w < N; w++) begin
            waitTx("rdb_tx_seen");
            tick(); tick(); tx_sent = 1'b1; tick(); tx_sent = 1'b0;
        end
        checkOutput("rdb_done", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("rdb_tx_count", n_tx - tx0, 32'd8);

`ifdef VOS_TIMEOUT_EN
        $display("[TB] watchdog");
        applyStimulus(8'h03);
        waitTx("wd_tx_seen");
        tick();
        repeat (99) tick();
        checkOutput("wd_not_yet", {31'd0, cmd_error}, 32'd0);
        tick();
        checkOutput("wd_err", {31'd0, cmd_error}, 32'd1);
        checkOutput("wd_idle", {31'd0, busy}, 32'd0);
        tick();
        applyStimulus(8'h03);
        waitTx("wd2_tx_seen");
        tick();
        repeat (99) tick();
        tx_sent = 1'b1;
        tick();
        tx_sent = 1'b0;
        checkOutput("wd_race_no_err", {31'd0, cmd_error}, 32'd0);
        checkOutput("wd_race_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1; tick(); reset = 1'b0; tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
